// File: rtl/history_input_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS AXI-Stream sources into one stream.
// Optional per-port packet counters are enabled by defining HIST_ARB_PKT_CNT_EN.
module history_input_arbiter #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_INPUTS         = 4,
    localparam int unsigned GW                = $clog2(NUM_INPUTS)
) (
    input  logic                                      axis_aclk,
    input  logic                                      axis_resetn,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_INPUTS-1:0]                     s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]                     s_axis_tready,
    input  logic [NUM_INPUTS-1:0]                     s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast,
    input  logic [NUM_INPUTS-1:0]                     port_en,
    output logic [GW-1:0]                             cur_port,
    output logic                                      busy
`ifdef HIST_ARB_PKT_CNT_EN
    ,
    output logic [NUM_INPUTS*32-1:0]                  pkt_cnt,
    input  logic                                      pkt_cnt_clr
`endif
);

    localparam int unsigned DW = C_AXIS_DATA_WIDTH;
    localparam int unsigned KW = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW = C_AXIS_TUSER_WIDTH;

    typedef enum logic [0:0] {StIdle, StPass} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   last_grant_q, cur_port_q;
    logic [GW-1:0]   grant, idx;
    logic            found;
    logic [NUM_INPUTS-1:0] req;
    logic            pkt_done;

    logic [DW-1:0]   s_data [NUM_INPUTS];
    logic [KW-1:0]   s_keep [NUM_INPUTS];
    logic [UW-1:0]   s_user [NUM_INPUTS];

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_unpack
        assign s_data[k] = s_axis_tdata[k*DW +: DW];
        assign s_keep[k] = s_axis_tkeep[k*KW +: KW];
        assign s_user[k] = s_axis_tuser[k*UW +: UW];
    end

    assign req      = s_axis_tvalid & port_en;
    assign cur_port = cur_port_q;
    assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Search starts just after the previous winner, so no port has fixed priority.
    always_comb begin
        grant = last_grant_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_INPUTS; i++) begin
            idx = GW'((32'(last_grant_q) + i) % NUM_INPUTS);
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req) state_d = StPass;
            StPass:  if (pkt_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b0;
        if (state_q == StPass) begin
            busy                      = 1'b1;
            m_axis_tdata              = s_data[cur_port_q];
            m_axis_tkeep              = s_keep[cur_port_q];
            m_axis_tuser              = s_user[cur_port_q];
            m_axis_tvalid             = s_axis_tvalid[cur_port_q];
            m_axis_tlast              = s_axis_tlast[cur_port_q];
            s_axis_tready[cur_port_q] = m_axis_tready;
        end
    end

    // Reset pointer to the last port so port 0 wins the first arbitration.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            last_grant_q <= GW'(NUM_INPUTS - 1);
            cur_port_q   <= '0;
        end else if (state_q == StIdle && |req) begin
            last_grant_q <= grant;
            cur_port_q   <= grant;
        end
    end

`ifdef HIST_ARB_PKT_CNT_EN
    logic [31:0] cnt_q [NUM_INPUTS];

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int k = 0; k < NUM_INPUTS; k++) cnt_q[k] <= '0;
        end else if (pkt_cnt_clr) begin
            for (int k = 0; k < NUM_INPUTS; k++) cnt_q[k] <= '0;
        end else if (pkt_done) begin
            cnt_q[cur_port_q] <= cnt_q[cur_port_q] + 32'd1;
        end
    end

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_cnt
        assign pkt_cnt[k*32 +: 32] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_history_input_arbiter.sv
// Self-checking bench for history_input_arbiter: directed table, hand sequences, random vs model.
module tb_history_input_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int UW  = 16;
    localparam int KW  = DW / 8;
    localparam int GWT = $clog2(N);

    logic              clk = 1'b0;
    logic              axis_resetn = 1'b0;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N*UW-1:0]   s_axis_tuser;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [N-1:0]      s_axis_tlast;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [N-1:0]      port_en;
    logic [GWT-1:0]    cur_port;
    logic              busy;
`ifdef HIST_ARB_PKT_CNT_EN
    logic [N*32-1:0]   pkt_cnt;
    logic              pkt_cnt_clr;
    logic [31:0]       cnt_o [N];
    int unsigned       mcnt [N];
`endif

    // Source-side state, packed onto the DUT ports below.
    logic [DW-1:0] td [N];
    logic          tv [N];
    logic          tl [N];

    int total = 0;
    int bad   = 0;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign s_axis_tdata[k*DW +: DW] = td[k];
        assign s_axis_tkeep[k*KW +: KW] = td[k][KW-1:0];
        assign s_axis_tuser[k*UW +: UW] = td[k][UW+7:8];
        assign s_axis_tvalid[k]         = tv[k];
        assign s_axis_tlast[k]          = tl[k];
`ifdef HIST_ARB_PKT_CNT_EN
        assign cnt_o[k] = pkt_cnt[k*32 +: 32];
`endif
    end

    history_input_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_INPUTS        (N)
    ) dut (
        .axis_aclk    (clk),
        .axis_resetn  (axis_resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .port_en      (port_en),
        .cur_port     (cur_port),
        .busy         (busy)
`ifdef HIST_ARB_PKT_CNT_EN
        ,
        .pkt_cnt      (pkt_cnt),
        .pkt_cnt_clr  (pkt_cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] vld;
        int           exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dat(input int k, input int p, input int b);
        logic [DW-1:0] r;
        r = {8'(k), 16'(p), 8'(b), 32'(k * 7919 + p * 31 + b) ^ 32'h5A5A_C3C3};
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r = N'(1) << k;
        return r;
    endfunction

    // Round-robin choice: first requester after the previous winner.
    function automatic int pick(input int p, input logic [N-1:0] rq);
        for (int j = 1; j <= N; j++) begin
            if (rq[GWT'((p + j) % N)]) return (p + j) % N;
        end
        return -1;
    endfunction

    task automatic set_src(input int k, input logic [DW-1:0] d, input logic last, input logic v);
        td[k] = d;
        tl[k] = last;
        tv[k] = v;
    endtask

    task automatic reset_dut();
        axis_resetn   = 1'b0;
        m_axis_tready = 1'b0;
        for (int k = 0; k < N; k++) set_src(k, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        axis_resetn = 1'b1;
        #1;
        chk("rst_state", {busy, m_axis_tvalid, s_axis_tready, cur_port, m_axis_tdata}, '0);
    endtask

    // One packet from port k; rdy bit per cycle drives m_axis_tready; optional intruder / en drop.
    task automatic send_pkt(input int k, input int n, input logic [15:0] rdy, input int intr,
                            input int intr_at, input bit drop);
        int   b;
        int   cyc;
        logic r;
        b   = 0;
        cyc = 0;
        set_src(k, dat(k, 200, 0), n == 1, 1'b1);
        m_axis_tready = 1'b1;
        #1;
        chk("pre_grant", {busy, m_axis_tvalid, s_axis_tready}, '0);
        tick();
        chk("grant", cur_port, k);
        if (drop) port_en = port_en & ~onehot(k);
        while (b < n && cyc < 64) begin
            r = rdy[4'(cyc)];
            m_axis_tready = r;
            if (intr >= 0 && b >= intr_at) set_src(intr, dat(intr, 200, 0), 1'b1, 1'b1);
            #1;
            chk("pkt_beat", {busy, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                {1'b1, 1'b1, b == n - 1, dat(k, 200, b)});
            chk("pkt_rdy", s_axis_tready, r ? onehot(k) : '0);
            tick();
            cyc++;
            if (r) begin
                b++;
                if (b < n) set_src(k, dat(k, 200, b), b == n - 1, 1'b1);
                else set_src(k, '0, 1'b0, 1'b0);
            end
        end
        if (b < n) chk("pkt_timeout", 128'(b), 128'(n));
        m_axis_tready = 1'b1;
        #1;
        chk("bubble", {busy, m_axis_tvalid}, '0);
        if (drop) port_en = port_en | onehot(k);
    endtask

    initial begin
        int            own;
        int            ptr;
        int            g;
        bit            own_v;
        bit            acc;
        bit            fin;
        logic [N-1:0]  rq;
        logic [DW-1:0] d;
        int            pid [N];
        int            bt [N];
        int            ln [N];
        bit            sv [N];

        tbl[0]  = '{4'b1111, 4'b1111, 0};
        tbl[1]  = '{4'b1111, 4'b1111, 1};
        tbl[2]  = '{4'b1111, 4'b1111, 2};
        tbl[3]  = '{4'b1111, 4'b1111, 3};
        tbl[4]  = '{4'b1111, 4'b1111, 0};
        tbl[5]  = '{4'b1111, 4'b0100, 2};
        tbl[6]  = '{4'b1101, 4'b0111, 0};
        tbl[7]  = '{4'b1101, 4'b0111, 2};
        tbl[8]  = '{4'b1101, 4'b0111, 0};
        tbl[9]  = '{4'b1111, 4'b1000, 3};
        tbl[10] = '{4'b1111, 4'b0011, 0};
        tbl[11] = '{4'b1111, 4'b1001, 3};

        port_en = '1;
`ifdef HIST_ARB_PKT_CNT_EN
        pkt_cnt_clr = 1'b0;
`endif
        reset_dut();

        // Single 3-beat packet from port 2 straight after reset.
        send_pkt(2, 3, 16'hFFFF, -1, 0, 1'b0);
        // Port 0 raises valid during beat 2 of a 5-beat port-1 packet; it must wait.
        send_pkt(1, 5, 16'hFFFF, 0, 1, 1'b0);
        send_pkt(0, 1, 16'hFFFF, -1, 0, 1'b0);
        // Downstream ready toggling 1010 during a 4-beat packet from port 3.
        send_pkt(3, 4, 16'h5555, -1, 0, 1'b0);
        // Enable withdrawn mid-packet: the packet still completes.
        port_en = 4'b1101;
        send_pkt(0, 3, 16'hFFFF, -1, 0, 1'b1);
        port_en = '1;

        // Arbitration table, one single-beat packet per record.
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            port_en       = tbl[i].en;
            m_axis_tready = 1'b1;
            for (int k = 0; k < N; k++) set_src(k, dat(k, i, 0), 1'b1, tbl[i].vld[GWT'(k)]);
            #1;
            chk("tbl_idle", {busy, m_axis_tvalid}, '0);
            tick();
            chk("tbl_grant", cur_port, tbl[i].exp);
            chk("tbl_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready},
                {1'b1, 1'b1, dat(tbl[i].exp, i, 0), onehot(tbl[i].exp)});
            tick();
        end
        for (int k = 0; k < N; k++) set_src(k, '0, 1'b0, 1'b0);
        port_en = '1;

        // Reset asserted during beat 2 of a packet.
        set_src(1, dat(1, 300, 0), 1'b0, 1'b1);
        m_axis_tready = 1'b1;
        tick();
        tick();
        set_src(1, dat(1, 300, 1), 1'b0, 1'b1);
        set_src(0, dat(0, 300, 0), 1'b1, 1'b1);
        set_src(3, dat(3, 300, 0), 1'b1, 1'b1);
        #1;
        chk("rst_mid_pass", {busy, m_axis_tdata}, {1'b1, dat(1, 300, 1)});
        axis_resetn = 1'b0;
        #1;
        chk("rst_mid_out", {busy, m_axis_tvalid, m_axis_tlast, s_axis_tready, cur_port,
                            m_axis_tdata, m_axis_tkeep, m_axis_tuser}, '0);
        #1;
        axis_resetn = 1'b1;
        tick();
        chk("rst_regrant", {busy, cur_port}, {1'b1, GWT'(0)});

`ifdef HIST_ARB_PKT_CNT_EN
        reset_dut();
        repeat (5) send_pkt(0, 1, 16'hFFFF, -1, 0, 1'b0);
        repeat (2) send_pkt(3, 1, 16'hFFFF, -1, 0, 1'b0);
        chk("cnt_vals", {cnt_o[3], cnt_o[2], cnt_o[1], cnt_o[0]}, {32'd2, 32'd0, 32'd0, 32'd5});
        pkt_cnt_clr = 1'b1;
        tick();
        pkt_cnt_clr = 1'b0;
        #1;
        chk("cnt_clr", {cnt_o[3], cnt_o[2], cnt_o[1], cnt_o[0]}, '0);
        set_src(0, dat(0, 400, 0), 1'b1, 1'b1);
        tick();
        pkt_cnt_clr = 1'b1;
        tick();
        pkt_cnt_clr = 1'b0;
        set_src(0, '0, 1'b0, 1'b0);
        #1;
        chk("cnt_clr_wins", cnt_o[0], 32'd0);
`endif

        // Randomized traffic against a transaction-level round-robin model.
        reset_dut();
        port_en = '1;
        own     = 0;
        own_v   = 1'b0;
        ptr     = N - 1;
        for (int k = 0; k < N; k++) begin
            pid[k] = 0;
            bt[k]  = 0;
            ln[k]  = 1 + int'($urandom_range(3));
            sv[k]  = 1'b0;
`ifdef HIST_ARB_PKT_CNT_EN
            mcnt[k] = 0;
`endif
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) set_src(k, dat(k, pid[k], bt[k]), bt[k] == ln[k] - 1, sv[k]);
            m_axis_tready = ($urandom_range(3) != 0);
            #1;
            if (!own_v) begin
                chk("rnd_idle", {busy, m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata}, '0);
            end else begin
                d = dat(own, pid[own], bt[own]);
                chk("rnd_port", {busy, cur_port}, {1'b1, GWT'(own)});
                chk("rnd_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                    {sv[own], bt[own] == ln[own] - 1, d});
                chk("rnd_side", {m_axis_tkeep, m_axis_tuser}, {d[KW-1:0], d[UW+7:8]});
                chk("rnd_rdy", s_axis_tready, m_axis_tready ? onehot(own) : '0);
            end
            acc = own_v && sv[own] && m_axis_tready;
            fin = acc && (bt[own] == ln[own] - 1);
            rq  = '0;
            for (int k = 0; k < N; k++) if (sv[k]) rq = rq | (onehot(k) & port_en);
            g = own_v ? -1 : pick(ptr, rq);
            tick();
            if (fin) begin
                own_v = 1'b0;
`ifdef HIST_ARB_PKT_CNT_EN
                mcnt[own]++;
`endif
            end else if (g >= 0) begin
                own   = g;
                ptr   = g;
                own_v = 1'b1;
            end
            if (acc) begin
                bt[own]++;
                if (bt[own] == ln[own]) begin
                    bt[own] = 0;
                    pid[own]++;
                    ln[own] = 1 + int'($urandom_range(3));
                end
                sv[own] = $urandom_range(1) != 0;
            end
            for (int k = 0; k < N; k++) if (!sv[k]) sv[k] = ($urandom_range(2) == 0);
            if ($urandom_range(11) == 0) port_en = port_en ^ onehot(int'($urandom_range(N - 1)));
        end
`ifdef HIST_ARB_PKT_CNT_EN
        for (int k = 0; k < N; k++) chk("rnd_cnt", cnt_o[k], mcnt[k]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
